sr_flag_scheduler: RTL and testbench

SR_FLAG_SCHEDULER -- requirements
Module: sr_flag_scheduler

---
 rtl/sr_sched_pkg.sv | 17 +
 rtl/sr_flag_scheduler_arb.sv | 52 +++++
 rtl/sr_flag_scheduler.sv | 164 ++++++++++++++++
 tb/tb_sr_flag_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR flag scheduler: FSM states, op encoding, default sizes.
package sr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_NUM_FLAGS   = 8;
    localparam int unsigned DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/sr_flag_scheduler_arb.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last advanced winner.
module rr_arbiter
    import sr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] ptr_n;
    logic             found;

    // Two passes: requesters at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        grant  = '0;
        winner = ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (32'(ptr) <= i)) begin
                grant[i] = 1'b1;
                winner   = PTR_W'(i);
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                winner   = PTR_W'(i);
                found    = 1'b1;
            end
        end
        ptr_n = (32'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
    end

    // Pointer moves past the winner only when a grant is actually taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_n;
        end
    end

endmodule

// File: rtl/sr_flag_scheduler.sv
// SR flag scheduler: arbitrates set/clear commands onto a flag bank with held s/r pulses.
// Optional sticky opposite-op collision detector: SR_SCHED_CONFLICT_CHECK_EN.
module sr_flag_scheduler
    import sr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned NUM_FLAGS   = DEF_NUM_FLAGS,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_op,
    input  logic [NUM_REQ*$clog2(NUM_FLAGS)-1:0] req_idx,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_FLAGS-1:0]               s,
    output logic [NUM_FLAGS-1:0]               r,
    output logic [NUM_FLAGS-1:0]               q,
`ifdef SR_SCHED_CONFLICT_CHECK_EN
    output logic                               conflict,
`endif
    output logic                               busy
);

    localparam int unsigned IDX_W = $clog2(NUM_FLAGS);
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 op_q, op_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [NUM_FLAGS-1:0] s_n, r_n, q_n;
    logic                 busy_n;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept_c;
    logic                 win_op;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_FLAGS-1:0] win_mask, cur_mask;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept_c),
        .grant   (grant)
    );

    // Ready is only offered while idle and out of reset.
    assign req_ready = ((state == IDLE) && reset) ? grant : '0;

    // Pick the winner's command and decode flag masks; out-of-range indices give an empty mask.
    always_comb begin
        win_op  = OP_CLR;
        win_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                win_op  = req_op[k];
                win_idx = req_idx[k*IDX_W +: IDX_W];
            end
        end
        win_mask = '0;
        cur_mask = '0;
        for (int unsigned f = 0; f < NUM_FLAGS; f++) begin
            win_mask[f] = (32'(win_idx) == f);
            cur_mask[f] = (32'(idx_q) == f);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        op_n     = op_q;
        idx_n    = idx_q;
        s_n      = s;
        r_n      = r;
        q_n      = q;
        accept_c = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    accept_c = 1'b1;
                    op_n     = win_op;
                    idx_n    = win_idx;
                    cnt_n    = CNT_W'(HOLD_CYCLES);
                    s_n      = (win_op == OP_SET) ? win_mask : '0;
                    r_n      = (win_op == OP_CLR) ? win_mask : '0;
                    state_n  = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(1)) begin
                    cnt_n   = '0;
                    s_n     = '0;
                    r_n     = '0;
                    q_n     = (op_q == OP_SET) ? (q | cur_mask) : (q & ~cur_mask);
                    state_n = RECOVER;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RECOVER: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and registered outputs; reset drops s/r immediately and discards the command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_CLR;
            idx_q <= '0;
            s     <= '0;
            r     <= '0;
            q     <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            idx_q <= idx_n;
            s     <= s_n;
            r     <= r_n;
            q     <= q_n;
            busy  <= busy_n;
        end
    end

`ifdef SR_SCHED_CONFLICT_CHECK_EN
    logic clash_c;

    // Two idle-phase requesters hitting the same flag with opposite ops.
    always_comb begin
        clash_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = i + 1; j < NUM_REQ; j++) begin
                if (req_valid[i] && req_valid[j] && (req_op[i] != req_op[j]) &&
                    (req_idx[i*IDX_W +: IDX_W] == req_idx[j*IDX_W +: IDX_W])) begin
                    clash_c = 1'b1;
                end
            end
        end
        if (state != IDLE) begin
            clash_c = 1'b0;
        end
    end

    // Sticky conflict flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict <= 1'b0;
        end else if (clash_c) begin
            conflict <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Self-checking bench for sr_flag_scheduler (NUM_REQ=4, NUM_FLAGS=8, HOLD_CYCLES=2),
// plus a NUM_FLAGS=6 instance for out-of-range indices. Honours SR_SCHED_CONFLICT_CHECK_EN.
`timescale 1ns/1ps
module tb_sr_flag_scheduler;

    localparam int unsigned IW = 3;
    localparam int          H  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_op, req_ready;
    logic [11:0] req_idx;
    logic [7:0]  s, r, q;
    logic        busy;
`ifdef SR_SCHED_CONFLICT_CHECK_EN
    logic        conflict;
    logic        b_conflict;
`endif
    logic [3:0]  b_valid, b_op, b_ready;
    logic [11:0] b_idx;
    logic [5:0]  b_s, b_r, b_q;
    logic        b_busy;

    sr_flag_scheduler #(.NUM_REQ(4), .NUM_FLAGS(8), .HOLD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
        .req_ready(req_ready), .s(s), .r(r), .q(q),
`ifdef SR_SCHED_CONFLICT_CHECK_EN
        .conflict(conflict),
`endif
        .busy(busy)
    );

    sr_flag_scheduler #(.NUM_REQ(4), .NUM_FLAGS(6), .HOLD_CYCLES(2)) dut6 (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_op(b_op), .req_idx(b_idx),
        .req_ready(b_ready), .s(b_s), .r(b_r), .q(b_q),
`ifdef SR_SCHED_CONFLICT_CHECK_EN
        .conflict(b_conflict),
`endif
        .busy(b_busy)
    );

    typedef struct {
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] q;
        logic       busy;
    } exp_t;

    typedef struct {
        int         k;
        logic       op;
        logic [2:0] idx;
        logic [7:0] exp_q;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_acc = 0;
    logic [7:0] cur_q = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Invariants every cycle, and scoreboard comparison for cycles following an accept.
    always @(negedge clk) begin
        chk("s_and_r_zero", 32'(s & r), 32'h0);
        chk("sr_onehot", 32'($countones(s | r) <= 1), 32'h1);
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'h1);
        chk("b_s_and_r_zero", 32'(b_s & b_r), 32'h0);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_s", 32'(s), 32'(mon_e.s));
            chk("sb_r", 32'(r), 32'(mon_e.r));
            chk("sb_q", 32'(q), 32'(mon_e.q));
            chk("sb_busy", 32'(busy), 32'(mon_e.busy));
            if (mon_e.busy) chk("sb_ready_low", 32'(req_ready), 32'h0);
        end
    end

    // Present a command, wait for its grant, then queue the expected per-cycle outputs.
    task automatic issue(input int k, input logic op, input logic [2:0] idx, input logic [7:0] exp_q,
                         input bit gap, input bit drop, output int waited);
        exp_t       e;
        logic [7:0] m;
        req_valid[k]            = 1'b1;
        req_op[k]               = op;
        req_idx[k*IW +: IW]     = idx;
        waited = 0;
        @(negedge clk);
        while (req_ready == 4'h0 && waited < 30) begin
            waited++;
            @(negedge clk);
        end
        chk("grant", 32'(req_ready), 32'(1) << k);
        if (req_ready == 4'h0) return;
        if (gap) chk("accept_gap", 32'(cyc - last_acc), 32'(H + 2));
        last_acc = cyc;
        @(posedge clk);
        #1;
        if (drop) req_valid[k] = 1'b0;
        m = 8'h01 << idx;
        for (int i = 0; i < H; i++) begin
            e.s = op ? m : 8'h00;
            e.r = op ? 8'h00 : m;
            e.q = cur_q;
            e.busy = 1'b1;
            sb.push_back(e);
        end
        e.s = 8'h00; e.r = 8'h00; e.q = exp_q; e.busy = 1'b1;
        sb.push_back(e);
        e.busy = 1'b0;
        sb.push_back(e);
        cur_q = exp_q;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    // One command on the NUM_FLAGS=6 instance, checked cycle by cycle.
    task automatic oor(input logic op, input logic [2:0] idx, input logic [5:0] s_exp,
                       input logic [5:0] r_exp, input logic [5:0] q_exp);
        int n = 0;
        b_valid[0] = 1'b1;
        b_op[0]    = op;
        b_idx[2:0] = idx;
        @(negedge clk);
        while (b_ready == 4'h0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("oor_grant", 32'(b_ready), 32'h1);
        @(posedge clk);
        #1;
        b_valid[0] = 1'b0;
        for (int i = 0; i < H; i++) begin
            @(negedge clk);
            chk("oor_s", 32'(b_s), 32'(s_exp));
            chk("oor_r", 32'(b_r), 32'(r_exp));
        end
        @(negedge clk);
        chk("oor_q", 32'(b_q), 32'(q_exp));
        chk("oor_recover_sr", 32'(b_s | b_r), 32'h0);
        @(negedge clk);
        chk("oor_idle", 32'(b_busy), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        int   order[5];
        logic [7:0] fq[5];
        int   w;
        int   n;

        tbl[0] = '{0, 1'b1, 3'd3, 8'h08};
        tbl[1] = '{0, 1'b0, 3'd3, 8'h00};
        tbl[2] = '{1, 1'b1, 3'd1, 8'h02};
        tbl[3] = '{3, 1'b1, 3'd1, 8'h02};
        tbl[4] = '{2, 1'b0, 3'd6, 8'h02};
        tbl[5] = '{3, 1'b1, 3'd7, 8'h82};
        tbl[6] = '{1, 1'b0, 3'd1, 8'h80};
        tbl[7] = '{0, 1'b0, 3'd7, 8'h00};
        tbl[8] = '{3, 1'b0, 3'd0, 8'h00};
        order = '{0, 1, 2, 3, 0};
        fq    = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};

        // Reset state, with requests pending to show ready stays low.
        reset     = 1'b0;
        req_valid = 4'hF;
        req_op    = 4'hF;
        req_idx   = '0;
        b_valid   = '0;
        b_op      = '0;
        b_idx     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_s", 32'(s), 32'h0);
        chk("rst_r", 32'(r), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef SR_SCHED_CONFLICT_CHECK_EN
        chk("rst_conflict", 32'(conflict), 32'h0);
`endif
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        req_op    = 4'h0;
        reset     = 1'b1;

`ifdef SR_SCHED_CONFLICT_CHECK_EN
        // Opposite ops on the same flag in one cycle: req0 wins, conflict sticks.
        req_valid[1]  = 1'b1;
        req_op[1]     = 1'b0;
        req_idx[5:3]  = 3'd2;
        issue(0, 1'b1, 3'd2, 8'h04, 1'b0, 1'b1, w);
        chk("conflict_set", 32'(conflict), 32'h1);
        issue(1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b1, w);
`endif

        // Table of single-requester commands, issued back to back.
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].k, tbl[i].op, tbl[i].idx, tbl[i].exp_q, (i > 0), 1'b1, w);
        end

        // Fairness: all four held valid, each setting its own flag.
        for (int k = 0; k < 4; k++) begin
            req_valid[k]        = 1'b1;
            req_op[k]           = 1'b1;
            req_idx[k*IW +: IW] = 3'(k);
        end
        for (int i = 0; i < 5; i++) begin
            issue(order[i], 1'b1, 3'(order[i]), fq[i], 1'b1, 1'b0, w);
        end
        req_valid = 4'h0;
        drain();

        // Reset during the first DRIVE cycle of a set on idx 5.
        req_valid[2]  = 1'b1;
        req_op[2]     = 1'b1;
        req_idx[8:6]  = 3'd5;
        n = 0;
        @(negedge clk);
        while (req_ready == 4'h0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("pre_rst_grant", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        chk("pre_rst_s", 32'(s), 32'h20);
        chk("pre_rst_busy", 32'(busy), 32'h1);
`ifdef SR_SCHED_CONFLICT_CHECK_EN
        chk("conflict_sticky", 32'(conflict), 32'h1);
`endif
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_s", 32'(s), 32'h0);
        chk("midrst_r", 32'(r), 32'h0);
        chk("midrst_q", 32'(q), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
`ifdef SR_SCHED_CONFLICT_CHECK_EN
        chk("midrst_conflict", 32'(conflict), 32'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        cur_q = 8'h00;
        issue(2, 1'b1, 3'd5, 8'h20, 1'b0, 1'b1, w);
        chk("post_rst_first_idle", 32'(w), 32'h0);
        drain();

        // Out-of-range indices on a 6-flag bank.
        oor(1'b1, 3'd7, 6'h00, 6'h00, 6'h00);
        oor(1'b1, 3'd5, 6'h20, 6'h00, 6'h20);
        oor(1'b1, 3'd6, 6'h00, 6'h00, 6'h20);
        oor(1'b0, 3'd7, 6'h00, 6'h00, 6'h20);
        oor(1'b0, 3'd5, 6'h00, 6'h20, 6'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
